// File: rtl/tlb_sv39_sa.sv
// tlb_sv39_sa: set-associative Sv39 TLB with a registered lookup response,
// tree-PLRU replacement per set, a fully-associative superpage array with
// round-robin fill and an SFENCE.VMA engine (single-cycle by address,
// multi-cycle set sweep for all / by ASID).
// Optional feature macro: TLB_SV39_HW_AD_EN (hardware A/D update: a clear
// A or D bit only raises the need bits, not a page fault).
module tlb_sv39_sa #(
  parameter int VPN_WIDTH  = 27,
  parameter int PPN_WIDTH  = 44,
  parameter int ASID_WIDTH = 16,
  parameter int SETS       = 16,
  parameter int WAYS       = 4,
  parameter int SP_ENTRIES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_valid,
  output logic                  lookup_ready,
  input  logic [VPN_WIDTH-1:0]  lookup_vpn,
  input  logic [ASID_WIDTH-1:0] lookup_asid,
  input  logic [1:0]            lookup_priv,
  input  logic                  lookup_is_store,
  input  logic                  lookup_is_exec,
  input  logic                  mstatus_sum,
  input  logic                  mstatus_mxr,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [PPN_WIDTH-1:0]  resp_ppn,
  output logic                  resp_page_fault,
  output logic                  resp_need_set_a,
  output logic                  resp_need_set_d,
  output logic [VPN_WIDTH-1:0]  resp_vpn,
  input  logic                  insert_valid,
  output logic                  insert_ready,
  input  logic [VPN_WIDTH-1:0]  insert_vpn,
  input  logic [PPN_WIDTH-1:0]  insert_ppn,
  input  logic [ASID_WIDTH-1:0] insert_asid,
  input  logic [1:0]            insert_page_size,
  input  logic [6:0]            insert_perm,
  input  logic                  inv_valid,
  input  logic [1:0]            inv_mode,
  input  logic [ASID_WIDTH-1:0] inv_asid,
  input  logic [VPN_WIDTH-1:0]  inv_vpn,
  output logic                  inv_busy
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int SP_W  = (SP_ENTRIES > 1) ? $clog2(SP_ENTRIES) : 1;
  localparam int PW    = WAYS - 1;

  typedef enum logic {IDLE, SWEEP} state_t;

  // perm layout {d,a,g,u,x,w,r}
  logic                  set_v    [SETS][WAYS];
  logic [VPN_WIDTH-1:0]  set_vpn  [SETS][WAYS];
  logic [PPN_WIDTH-1:0]  set_ppn  [SETS][WAYS];
  logic [ASID_WIDTH-1:0] set_asid [SETS][WAYS];
  logic [6:0]            set_perm [SETS][WAYS];
  logic [PW-1:0]         plru     [SETS];
  logic                  sp_v     [SP_ENTRIES];
  logic [VPN_WIDTH-1:0]  sp_vpn   [SP_ENTRIES];
  logic [PPN_WIDTH-1:0]  sp_ppn   [SP_ENTRIES];
  logic [ASID_WIDTH-1:0] sp_asid  [SP_ENTRIES];
  logic [6:0]            sp_perm  [SP_ENTRIES];
  logic                  sp_gb    [SP_ENTRIES];
  logic [SP_W-1:0]       sp_ptr_reg;

  state_t                state_reg;
  logic [IDX_W-1:0]      sweep_k_reg;
  logic                  sweep_by_asid_reg;
  logic [ASID_WIDTH-1:0] sweep_asid_reg;

  // Superpage VPN compare: low 9 (2 MB) or 18 (1 GB) VPN bits are page offset.
  function automatic logic sp_vmatch(input logic [VPN_WIDTH-1:0] e, input logic gb,
                                     input logic [VPN_WIDTH-1:0] q);
    logic [VPN_WIDTH-1:0] m;
    m = gb ? ~VPN_WIDTH'({18{1'b1}}) : ~VPN_WIDTH'({9{1'b1}});
    return ((e ^ q) & m) == '0;
  endfunction

  // Tree walk: node n (heap numbering from 1) stored at bit n-1; bit set = go right.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PW-1:0] b);
    int n;
    logic [PW-1:0] t;
    n = 1;
    for (int l = 0; l < WAY_W; l++) begin
      t = b >> (n - 1);
      n = 2 * n + (t[0] ? 1 : 0);
    end
    return WAY_W'(n - WAYS);
  endfunction

  // Point every node on the path away from the touched way.
  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] b, input logic [WAY_W-1:0] w);
    logic [PW-1:0] r, m;
    logic [WAY_W-1:0] ws;
    int n;
    r = b;
    n = 1;
    for (int l = 0; l < WAY_W; l++) begin
      ws = w >> (WAY_W - 1 - l);
      m = PW'(1) << (n - 1);
      r = ws[0] ? (r & ~m) : (r | m);
      n = 2 * n + (ws[0] ? 1 : 0);
    end
    return r;
  endfunction

  logic                 lk_acc, lk_set_hit, lk_sp_hit, lk_hit, lk_load, perm_fault;
  logic                 lk_fault, lk_need_a, lk_need_d;
  logic [IDX_W-1:0]     lk_idx, ins_idx, ia_idx;
  logic [WAY_W-1:0]     lk_set_way, ins_hit_way, ins_free_way, ins_way;
  logic [SP_W-1:0]      lk_sp_sel, ins_sp_hit_sel, ins_sp_sel;
  logic [6:0]           lk_perm;
  logic [PPN_WIDTH-1:0] lk_ppn, sp_mask;
  logic                 ins_do, ins_sp, ins_gb, ins_set_hit, ins_free, ins_sp_hit;
  logic                 inv_addr, inv_sweep_start;
  logic [PW-1:0]        plru_base;

  assign lookup_ready    = !inv_busy;
  assign insert_ready    = !inv_busy && !inv_valid;
  assign lk_acc          = lookup_valid && lookup_ready;
  assign ins_do          = insert_valid && insert_ready;
  assign inv_addr        = inv_valid && !inv_busy && inv_mode[1];
  assign inv_sweep_start = inv_valid && !inv_busy && !inv_mode[1];

  // Lookup match, hit priority (set before SP, lowest index first) and permission checks.
  always_comb begin
    lk_idx     = lookup_vpn[IDX_W-1:0];
    lk_set_hit = 1'b0;
    lk_set_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (set_v[lk_idx][w] && set_vpn[lk_idx][w] == lookup_vpn &&
          (set_perm[lk_idx][w][4] || set_asid[lk_idx][w] == lookup_asid)) begin
        lk_set_hit = 1'b1;
        lk_set_way = WAY_W'(w);
      end
    lk_sp_hit = 1'b0;
    lk_sp_sel = '0;
    for (int e = SP_ENTRIES - 1; e >= 0; e--)
      if (sp_v[e] && sp_vmatch(sp_vpn[e], sp_gb[e], lookup_vpn) &&
          (sp_perm[e][4] || sp_asid[e] == lookup_asid)) begin
        lk_sp_hit = 1'b1;
        lk_sp_sel = SP_W'(e);
      end
    sp_mask = sp_gb[lk_sp_sel] ? PPN_WIDTH'({18{1'b1}}) : PPN_WIDTH'({9{1'b1}});
    lk_perm = '0;
    lk_ppn  = '0;
    if (lk_set_hit) begin
      lk_perm = set_perm[lk_idx][lk_set_way];
      lk_ppn  = set_ppn[lk_idx][lk_set_way];
    end else if (lk_sp_hit) begin
      lk_perm = sp_perm[lk_sp_sel];
      lk_ppn  = (sp_ppn[lk_sp_sel] & ~sp_mask) | (PPN_WIDTH'(lookup_vpn) & sp_mask);
    end
    lk_hit     = lk_set_hit || lk_sp_hit;
    lk_load    = !lookup_is_store && !lookup_is_exec;
    perm_fault = (lookup_priv == 2'b00 && !lk_perm[3]) ||
                 (lookup_priv == 2'b01 && lk_perm[3] && !mstatus_sum) ||
                 (lookup_is_store && !lk_perm[1]) ||
                 (lookup_is_exec && !lk_perm[2]) ||
                 (lk_load && !lk_perm[0] && !(lk_perm[2] && mstatus_mxr));
    lk_need_a  = lk_hit && !perm_fault && !lk_perm[5];
    lk_need_d  = lk_hit && !perm_fault && lookup_is_store && !lk_perm[6];
`ifdef TLB_SV39_HW_AD_EN
    lk_fault   = lk_hit && perm_fault;
`else
    lk_fault   = lk_hit && (perm_fault || lk_need_a || lk_need_d);
`endif
  end

  // Insert target selection: hitting way, else lowest free way, else PLRU victim.
  always_comb begin
    ins_idx      = insert_vpn[IDX_W-1:0];
    ia_idx       = inv_vpn[IDX_W-1:0];
    ins_gb       = insert_page_size == 2'd2;
    ins_sp       = insert_page_size == 2'd1 || ins_gb;
    ins_set_hit  = 1'b0;
    ins_hit_way  = '0;
    ins_free     = 1'b0;
    ins_free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (set_v[ins_idx][w] && set_vpn[ins_idx][w] == insert_vpn &&
          (set_perm[ins_idx][w][4] || set_asid[ins_idx][w] == insert_asid)) begin
        ins_set_hit = 1'b1;
        ins_hit_way = WAY_W'(w);
      end
      if (!set_v[ins_idx][w]) begin
        ins_free     = 1'b1;
        ins_free_way = WAY_W'(w);
      end
    end
    ins_way = ins_set_hit ? ins_hit_way : (ins_free ? ins_free_way : plru_victim(plru[ins_idx]));
    ins_sp_hit     = 1'b0;
    ins_sp_hit_sel = '0;
    for (int e = SP_ENTRIES - 1; e >= 0; e--)
      if (sp_v[e] && sp_vmatch(sp_vpn[e], sp_gb[e], insert_vpn) &&
          (sp_perm[e][4] || sp_asid[e] == insert_asid)) begin
        ins_sp_hit     = 1'b1;
        ins_sp_hit_sel = SP_W'(e);
      end
    ins_sp_sel = ins_sp_hit ? ins_sp_hit_sel : sp_ptr_reg;
    plru_base  = (lk_acc && lk_set_hit && lk_idx == ins_idx) ?
                 plru_touch(plru[lk_idx], lk_set_way) : plru[ins_idx];
  end

  // Valid bits, PLRU state and SP pointer: fills, address invalidates, sweep clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        plru[s] <= '0;
        for (int w = 0; w < WAYS; w++) set_v[s][w] <= 1'b0;
      end
      for (int e = 0; e < SP_ENTRIES; e++) sp_v[e] <= 1'b0;
      sp_ptr_reg <= '0;
    end else begin
      if (ins_do) begin
        if (ins_sp) begin
          sp_v[ins_sp_sel] <= 1'b1;
          if (!ins_sp_hit)
            sp_ptr_reg <= (sp_ptr_reg == SP_W'(SP_ENTRIES - 1)) ? '0 : sp_ptr_reg + 1'b1;
        end else begin
          set_v[ins_idx][ins_way] <= 1'b1;
          plru[ins_idx] <= plru_touch(plru_base, ins_way);
        end
      end
      if (lk_acc && lk_set_hit && !(ins_do && !ins_sp && ins_idx == lk_idx))
        plru[lk_idx] <= plru_touch(plru[lk_idx], lk_set_way);
      if (inv_addr) begin
        for (int w = 0; w < WAYS; w++)
          if (set_vpn[ia_idx][w] == inv_vpn &&
              (!inv_mode[0] || (!set_perm[ia_idx][w][4] && set_asid[ia_idx][w] == inv_asid)))
            set_v[ia_idx][w] <= 1'b0;
        for (int e = 0; e < SP_ENTRIES; e++)
          if (sp_vmatch(sp_vpn[e], sp_gb[e], inv_vpn) &&
              (!inv_mode[0] || (!sp_perm[e][4] && sp_asid[e] == inv_asid)))
            sp_v[e] <= 1'b0;
      end
      if (state_reg == SWEEP) begin
        for (int w = 0; w < WAYS; w++)
          if (!sweep_by_asid_reg ||
              (!set_perm[sweep_k_reg][w][4] && set_asid[sweep_k_reg][w] == sweep_asid_reg))
            set_v[sweep_k_reg][w] <= 1'b0;
        if (sweep_k_reg == '0)
          for (int e = 0; e < SP_ENTRIES; e++)
            if (!sweep_by_asid_reg || (!sp_perm[e][4] && sp_asid[e] == sweep_asid_reg))
              sp_v[e] <= 1'b0;
      end
    end
  end

  // Entry payload storage; only meaningful behind a valid bit, so no reset.
  always_ff @(posedge clk) begin
    if (ins_do) begin
      if (ins_sp) begin
        sp_vpn[ins_sp_sel]  <= insert_vpn;
        sp_ppn[ins_sp_sel]  <= insert_ppn;
        sp_asid[ins_sp_sel] <= insert_asid;
        sp_perm[ins_sp_sel] <= insert_perm;
        sp_gb[ins_sp_sel]   <= ins_gb;
      end else begin
        set_vpn[ins_idx][ins_way]  <= insert_vpn;
        set_ppn[ins_idx][ins_way]  <= insert_ppn;
        set_asid[ins_idx][ins_way] <= insert_asid;
        set_perm[ins_idx][ins_way] <= insert_perm;
      end
    end
  end

  // Sweep FSM: IDLE accepts SFENCE, SWEEP walks one set per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      inv_busy          <= 1'b0;
      sweep_k_reg       <= '0;
      sweep_by_asid_reg <= 1'b0;
      sweep_asid_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: if (inv_sweep_start) begin
          state_reg         <= SWEEP;
          inv_busy          <= 1'b1;
          sweep_k_reg       <= '0;
          sweep_by_asid_reg <= inv_mode[0];
          sweep_asid_reg    <= inv_asid;
        end
        SWEEP: if (sweep_k_reg == IDX_W'(SETS - 1)) begin
          state_reg <= IDLE;
          inv_busy  <= 1'b0;
        end else begin
          sweep_k_reg <= sweep_k_reg + 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Registered lookup response; a miss reports all-zero status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid      <= 1'b0;
      resp_hit        <= 1'b0;
      resp_ppn        <= '0;
      resp_page_fault <= 1'b0;
      resp_need_set_a <= 1'b0;
      resp_need_set_d <= 1'b0;
      resp_vpn        <= '0;
    end else begin
      resp_valid      <= lk_acc;
      resp_hit        <= lk_acc && lk_hit;
      resp_ppn        <= lk_acc ? lk_ppn : '0;
      resp_page_fault <= lk_acc && lk_fault;
      resp_need_set_a <= lk_acc && lk_need_a;
      resp_need_set_d <= lk_acc && lk_need_d;
      resp_vpn        <= lookup_vpn;
    end
  end
endmodule

// File: tb/tb_tlb_sv39_sa.sv
// tb_tlb_sv39_sa: directed checks of tlb_sv39_sa (default parameters:
// 16 sets x 4 ways, 8 superpage entries). Honours TLB_SV39_HW_AD_EN.
module tb_tlb_sv39_sa;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lookup_valid = 0, lookup_ready;
  logic [26:0] lookup_vpn = '0;
  logic [15:0] lookup_asid = '0;
  logic [1:0]  lookup_priv = '0;
  logic        lookup_is_store = 0, lookup_is_exec = 0;
  logic        mstatus_sum = 0, mstatus_mxr = 0;
  logic        resp_valid, resp_hit, resp_page_fault, resp_need_set_a, resp_need_set_d;
  logic [43:0] resp_ppn;
  logic [26:0] resp_vpn;
  logic        insert_valid = 0, insert_ready;
  logic [26:0] insert_vpn = '0;
  logic [43:0] insert_ppn = '0;
  logic [15:0] insert_asid = '0;
  logic [1:0]  insert_page_size = '0;
  logic [6:0]  insert_perm = '0;
  logic        inv_valid = 0;
  logic [1:0]  inv_mode = '0;
  logic [15:0] inv_asid = '0;
  logic [26:0] inv_vpn = '0;
  logic        inv_busy;

  int checks = 0;
  int errors = 0;

`ifdef TLB_SV39_HW_AD_EN
  localparam bit AD_FAULT = 1'b0;
`else
  localparam bit AD_FAULT = 1'b1;
`endif

  tlb_sv39_sa dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready), .lookup_vpn(lookup_vpn),
    .lookup_asid(lookup_asid), .lookup_priv(lookup_priv), .lookup_is_store(lookup_is_store),
    .lookup_is_exec(lookup_is_exec), .mstatus_sum(mstatus_sum), .mstatus_mxr(mstatus_mxr),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_ppn(resp_ppn),
    .resp_page_fault(resp_page_fault), .resp_need_set_a(resp_need_set_a),
    .resp_need_set_d(resp_need_set_d), .resp_vpn(resp_vpn),
    .insert_valid(insert_valid), .insert_ready(insert_ready), .insert_vpn(insert_vpn),
    .insert_ppn(insert_ppn), .insert_asid(insert_asid), .insert_page_size(insert_page_size),
    .insert_perm(insert_perm), .inv_valid(inv_valid), .inv_mode(inv_mode),
    .inv_asid(inv_asid), .inv_vpn(inv_vpn), .inv_busy(inv_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_insert(input logic [26:0] vpn, input logic [43:0] ppn, input logic [15:0] asid,
                           input logic [1:0] size, input logic [6:0] perm);
    @(negedge clk);
    insert_valid = 1; insert_vpn = vpn; insert_ppn = ppn; insert_asid = asid;
    insert_page_size = size; insert_perm = perm;
    @(posedge clk); #1;
    insert_valid = 0;
    $display("insert vpn=0x%0h ppn=0x%0h asid=%0d size=%0d perm=0x%0h", vpn, ppn, asid, size, perm);
  endtask

  task automatic do_lookup(input string tag, input logic [26:0] vpn, input logic [15:0] asid,
                           input logic [1:0] priv, input logic st, input logic ex,
                           input logic exp_hit, input logic [43:0] exp_ppn, input logic exp_fault);
    @(negedge clk);
    lookup_valid = 1; lookup_vpn = vpn; lookup_asid = asid; lookup_priv = priv;
    lookup_is_store = st; lookup_is_exec = ex;
    @(posedge clk); #1;
    lookup_valid = 0;
    $display("lookup %s vpn=0x%0h -> valid=%0b hit=%0b ppn=0x%0h fault=%0b a=%0b d=%0b", tag, vpn,
             resp_valid, resp_hit, resp_ppn, resp_page_fault, resp_need_set_a, resp_need_set_d);
    check({tag, "_valid"}, 64'(resp_valid), 64'd1);
    check({tag, "_hit"}, 64'(resp_hit), 64'(exp_hit));
    if (exp_hit) check({tag, "_ppn"}, 64'(resp_ppn), 64'(exp_ppn));
    check({tag, "_fault"}, 64'(resp_page_fault), 64'(exp_fault));
  endtask

  // Issue an SFENCE (optionally with a lookup in the same cycle) and, for
  // sweeping modes, measure how long inv_busy stays high.
  task automatic do_inv(input string tag, input logic [1:0] mode, input logic [15:0] asid,
                        input logic [26:0] vpn, input logic with_lookup, input logic [26:0] lk_vpn);
    int cnt;
    @(negedge clk);
    inv_valid = 1; inv_mode = mode; inv_asid = asid; inv_vpn = vpn;
    insert_valid = 1; insert_vpn = 27'h7FFF0; insert_page_size = 0; insert_perm = 7'h7F;
    if (with_lookup) begin
      lookup_valid = 1; lookup_vpn = lk_vpn; lookup_asid = 16'd1; lookup_priv = 2'b11;
      lookup_is_store = 0; lookup_is_exec = 0;
    end
    #1;
    check({tag, "_insert_ready_low"}, 64'(insert_ready), 64'd0);
    @(posedge clk); #1;
    inv_valid = 0; insert_valid = 0; lookup_valid = 0;
    if (with_lookup) begin
      check({tag, "_inflight_valid"}, 64'(resp_valid), 64'd1);
      check({tag, "_inflight_hit"}, 64'(resp_hit), 64'd1);
    end
    cnt = 0;
    while (inv_busy === 1'b1 && cnt < 40) begin
      check({tag, "_ready_low"}, 64'(lookup_ready), 64'd0);
      cnt++;
      @(posedge clk); #1;
    end
    $display("inv %s mode=%0d busy_cycles=%0d", tag, mode, cnt);
    check({tag, "_busy_cycles"}, 64'(cnt), mode[1] ? 64'd0 : 64'd16);
    check({tag, "_ready_back"}, 64'(lookup_ready), 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_hit", 64'(resp_hit), 64'd0);
    check("rst_inv_busy", 64'(inv_busy), 64'd0);
    check("rst_lookup_ready", 64'(lookup_ready), 64'd1);
    check("rst_insert_ready", 64'(insert_ready), 64'd1);
    @(negedge clk);
    rst_n = 1;

    do_lookup("cold", 27'h12345, 16'd1, 2'b01, 0, 0, 0, 44'h0, 0);

    // 4 KB page with u=1: S-mode needs SUM
    do_insert(27'h00010, 44'hABC, 16'd1, 2'd0, 7'h7F);
    do_lookup("s_nosum", 27'h00010, 16'd1, 2'b01, 0, 0, 1, 44'hABC, 1);
    mstatus_sum = 1;
    do_lookup("s_sum", 27'h00010, 16'd1, 2'b01, 0, 0, 1, 44'hABC, 0);
    mstatus_sum = 0;

    // Fill set 0; PLRU bits become root=1,left=0,right=0 -> victim way 2 (0x30)
    do_insert(27'h00020, 44'h222, 16'd1, 2'd0, 7'h7F);
    do_insert(27'h00030, 44'h333, 16'd1, 2'd0, 7'h7F);
    do_insert(27'h00040, 44'h444, 16'd1, 2'd0, 7'h7F);
    do_lookup("touch20", 27'h00020, 16'd1, 2'b11, 0, 0, 1, 44'h222, 0);
    do_insert(27'h00050, 44'h555, 16'd1, 2'd0, 7'h7F);
    do_lookup("victim30", 27'h00030, 16'd1, 2'b11, 0, 0, 0, 44'h0, 0);
    do_lookup("keep10", 27'h00010, 16'd1, 2'b11, 0, 0, 1, 44'hABC, 0);
    do_lookup("keep20", 27'h00020, 16'd1, 2'b11, 0, 0, 1, 44'h222, 0);
    do_lookup("keep40", 27'h00040, 16'd1, 2'b11, 0, 0, 1, 44'h444, 0);
    do_lookup("new50", 27'h00050, 16'd1, 2'b11, 0, 0, 1, 44'h555, 0);

    // Superpages: 2 MB non-global, 1 GB global
    do_insert(27'h00400, 44'h200000, 16'd1, 2'd1, 7'h67);
    do_lookup("sp2m", 27'h00455, 16'd1, 2'b01, 0, 0, 1, 44'h200055, 0);
    do_lookup("sp2m_asid", 27'h00455, 16'd2, 2'b01, 0, 0, 0, 44'h0, 0);
    do_insert(27'h0C0000, 44'h80000, 16'd1, 2'd2, 7'h77);
    do_lookup("sp1g", 27'h0C1234, 16'd5, 2'b01, 0, 0, 1, 44'h81234, 0);

    // U page without W
    do_insert(27'h00061, 44'h661, 16'd1, 2'd0, 7'h6D);
    do_lookup("u_store", 27'h00061, 16'd1, 2'b00, 1, 0, 1, 44'h661, 1);
    do_lookup("u_load", 27'h00061, 16'd1, 2'b00, 0, 0, 1, 44'h661, 0);
    do_lookup("s_load_u", 27'h00061, 16'd1, 2'b01, 0, 0, 1, 44'h661, 1);

    // Execute-only page and MXR
    do_insert(27'h00083, 44'h883, 16'd1, 2'd0, 7'h64);
    do_lookup("xo_nomxr", 27'h00083, 16'd1, 2'b01, 0, 0, 1, 44'h883, 1);
    mstatus_mxr = 1;
    do_lookup("xo_mxr", 27'h00083, 16'd1, 2'b01, 0, 0, 1, 44'h883, 0);
    mstatus_mxr = 0;
    do_lookup("xo_exec", 27'h00083, 16'd1, 2'b01, 0, 1, 1, 44'h883, 0);

    // A/D handling and in-place update
    do_insert(27'h00072, 44'h772, 16'd1, 2'd0, 7'h07);
    do_lookup("ad_load", 27'h00072, 16'd1, 2'b01, 0, 0, 1, 44'h772, AD_FAULT);
    check("ad_load_need_a", 64'(resp_need_set_a), 64'd1);
    check("ad_load_need_d", 64'(resp_need_set_d), 64'd0);
    do_lookup("ad_store", 27'h00072, 16'd1, 2'b01, 1, 0, 1, 44'h772, AD_FAULT);
    check("ad_store_need_a", 64'(resp_need_set_a), 64'd1);
    check("ad_store_need_d", 64'(resp_need_set_d), 64'd1);
    do_insert(27'h00072, 44'h772, 16'd1, 2'd0, 7'h67);
    do_lookup("ad_fixed", 27'h00072, 16'd1, 2'b01, 1, 0, 1, 44'h772, 0);
    check("ad_fixed_need_a", 64'(resp_need_set_a), 64'd0);
    check("ad_fixed_need_d", 64'(resp_need_set_d), 64'd0);

    // By-address invalidate (single cycle)
    do_inv("inv_addr", 2'd2, 16'd0, 27'h00020, 0, 27'h0);
    do_lookup("gone20", 27'h00020, 16'd1, 2'b11, 0, 0, 0, 44'h0, 0);
    do_lookup("still40", 27'h00040, 16'd1, 2'b11, 0, 0, 1, 44'h444, 0);
    do_lookup("dropped_ins", 27'h7FFF0, 16'd1, 2'b11, 0, 0, 0, 44'h0, 0);

    // By-ASID sweep keeps global entries
    do_inv("inv_asid", 2'd1, 16'd1, 27'h0, 0, 27'h0);
    do_lookup("g40_kept", 27'h00040, 16'd1, 2'b11, 0, 0, 1, 44'h444, 0);
    do_lookup("sp2m_gone", 27'h00455, 16'd1, 2'b01, 0, 0, 0, 44'h0, 0);
    do_lookup("u61_gone", 27'h00061, 16'd1, 2'b00, 0, 0, 0, 44'h0, 0);
    do_lookup("sp1g_kept", 27'h0C1234, 16'd1, 2'b01, 0, 0, 1, 44'h81234, 0);

    // Flush-all sweep with an in-flight lookup in the accept cycle
    do_inv("inv_all", 2'd0, 16'd0, 27'h0, 1, 27'h00040);
    do_lookup("all40", 27'h00040, 16'd1, 2'b11, 0, 0, 0, 44'h0, 0);
    do_lookup("all10", 27'h00010, 16'd1, 2'b11, 0, 0, 0, 44'h0, 0);
    do_lookup("all1g", 27'h0C1234, 16'd1, 2'b01, 0, 0, 0, 44'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
